i2s_receiver: RTL and testbench

Serial-to-parallel I2S receiver; the receive end of the team's I2S serial audio link. It samples word_select and serial data on serial_clk and recovers left/right PCM words. It delivers each stereo pair as a one-cycle-valid parallel frame to downstream audio-processing logic in the serial_clk domain. It also detects framing errors and provides lock status.

---
 rtl/i2s_receiver.sv | 203 ++++++++++++++++++++
 tb/tb_i2s_receiver.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_receiver.sv
// ============================================================================
// i2s_receiver
// ----------------------------------------------------------------------------
// Receive end of the I2S serial audio link. It samples word_select and
// sound_bit_in on every rising serial_clk, rebuilds the left and right PCM
// words, and hands each complete stereo pair to downstream logic as a
// one-cycle-valid parallel frame. Framing problems are reported through
// short_word (a slot shorter than DATA_WIDTH) and sync_lost (a slot longer
// than MAX_SLOT_BITS). locked shows whether the receiver is aligned to the
// frame structure.
//
// Parameters
//   DATA_WIDTH     bits kept per channel, MSB first; further slot bits drop
//   MAX_SLOT_BITS  longest legal slot; one more bit without a word_select
//                  transition is treated as loss of sync
//
// Ports
//   serial_clk    in   bit clock; all logic on its rising edge
//   reset         in   asynchronous, active-high reset
//   word_select   in   0 = left slot, 1 = right slot
//   sound_bit_in  in   serial data, MSB first, one bit after word_select
//   left_sample   out  last complete left word
//   right_sample  out  last complete right word
//   sample_valid  out  one-cycle pulse; both words updated together
//   short_word    out  qualifies sample_valid: a slot of the frame was short
//   sync_lost     out  one-cycle pulse on slot overrun
//   locked        out  high whenever the receiver is not acquiring
// ============================================================================
module i2s_receiver #(
    parameter int DATA_WIDTH    = 16,
    parameter int MAX_SLOT_BITS = 32
) (
    input  logic                  serial_clk,
    input  logic                  reset,
    input  logic                  word_select,
    input  logic                  sound_bit_in,
    output logic [DATA_WIDTH-1:0] left_sample,
    output logic [DATA_WIDTH-1:0] right_sample,
    output logic                  sample_valid,
    output logic                  short_word,
    output logic                  sync_lost,
    output logic                  locked
);

    // Wide enough to hold MAX_SLOT_BITS itself.
    localparam int CW = $clog2(MAX_SLOT_BITS + 1);

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        LEFT    = 2'd1,
        RIGHT   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                state_q;
    logic                  ws_prev_q;      // word_select seen on the previous edge
    logic [CW-1:0]         cnt_q;          // bits received so far in this slot
    logic [DATA_WIDTH-1:0] shift_q;        // word being assembled for this slot
    logic [DATA_WIDTH-1:0] left_word_q;    // finished left word awaiting its right
    logic                  frame_short_q;  // left slot of this frame was short

    logic [DATA_WIDTH-1:0] left_sample_q;
    logic [DATA_WIDTH-1:0] right_sample_q;
    logic                  sample_valid_q;
    logic                  short_word_q;
    logic                  sync_lost_q;
    logic                  locked_q;

    // ------------------------------------------------------------------
    // Per-edge decode
    // ------------------------------------------------------------------
    logic                  ws_rise;
    logic                  ws_fall;
    logic [CW-1:0]         cnt_d;          // slot bit count including this edge
    logic [DATA_WIDTH-1:0] bit_mask;       // one-hot position for this bit
    logic [DATA_WIDTH-1:0] slot_word_d;    // slot word including this edge's bit
    logic                  slot_short_d;   // slot ended before DATA_WIDTH bits
    logic                  overrun_d;

    // The bit sampled on a transition edge still belongs to the old slot, so
    // every edge adds its bit to the current slot before any state change.
    assign ws_rise = word_select & ~ws_prev_q;
    assign ws_fall = ~word_select & ws_prev_q;

    // Saturating count: the slot is abandoned at MAX_SLOT_BITS, but the
    // counter must never wrap to a small value if that ever slips.
    assign cnt_d = (cnt_q == CW'(MAX_SLOT_BITS)) ? cnt_q : cnt_q + CW'(1);

    // Bit n of the slot lands at word position DATA_WIDTH-1-n. Once the count
    // passes DATA_WIDTH no mask bit matches, which drops the extra bits. The
    // assembly register starts each slot at zero, so a short slot comes out
    // left-justified with zero-filled LSBs without any extra shifting.
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit_mask
        assign bit_mask[gi] = (cnt_q == CW'(DATA_WIDTH - 1 - gi));
    end

    assign slot_word_d  = shift_q | (sound_bit_in ? bit_mask : '0);
    assign slot_short_d = (cnt_d < CW'(DATA_WIDTH));

    // A transition on the edge that would reach the limit wins: the slot is
    // exactly MAX_SLOT_BITS long and is legal.
    assign overrun_d = (cnt_d == CW'(MAX_SLOT_BITS));

    // ------------------------------------------------------------------
    // Receiver FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge serial_clk or posedge reset) begin
        if (reset) begin
            state_q        <= ACQUIRE;
            ws_prev_q      <= 1'b0;
            cnt_q          <= '0;
            shift_q        <= '0;
            left_word_q    <= '0;
            frame_short_q  <= 1'b0;
            left_sample_q  <= '0;
            right_sample_q <= '0;
            sample_valid_q <= 1'b0;
            short_word_q   <= 1'b0;
            sync_lost_q    <= 1'b0;
            locked_q       <= 1'b0;
        end else begin
            ws_prev_q      <= word_select;
            sample_valid_q <= 1'b0;
            sync_lost_q    <= 1'b0;

            case (state_q)
                ACQUIRE: begin
                    // Only the start of a left slot gives a clean frame
                    // boundary; everything before it is ignored.
                    if (ws_fall) begin
                        state_q       <= LEFT;
                        cnt_q         <= '0;
                        shift_q       <= '0;
                        frame_short_q <= 1'b0;
                        locked_q      <= 1'b1;
                    end
                end

                LEFT: begin
                    if (ws_rise) begin
                        left_word_q   <= slot_word_d;
                        frame_short_q <= slot_short_d;
                        cnt_q         <= '0;
                        shift_q       <= '0;
                        state_q       <= RIGHT;
                    end else if (overrun_d) begin
                        // Output words are left alone; only the frame in
                        // progress is abandoned.
                        sync_lost_q <= 1'b1;
                        locked_q    <= 1'b0;
                        cnt_q       <= '0;
                        shift_q     <= '0;
                        state_q     <= ACQUIRE;
                    end else begin
                        shift_q <= slot_word_d;
                        cnt_q   <= cnt_d;
                    end
                end

                RIGHT: begin
                    if (ws_fall) begin
                        // End of the right slot closes the frame; the
                        // falling edge also starts the next left slot.
                        left_sample_q  <= left_word_q;
                        right_sample_q <= slot_word_d;
                        sample_valid_q <= 1'b1;
                        short_word_q   <= frame_short_q | slot_short_d;
                        frame_short_q  <= 1'b0;
                        cnt_q          <= '0;
                        shift_q        <= '0;
                        state_q        <= LEFT;
                    end else if (overrun_d) begin
                        sync_lost_q <= 1'b1;
                        locked_q    <= 1'b0;
                        cnt_q       <= '0;
                        shift_q     <= '0;
                        state_q     <= ACQUIRE;
                    end else begin
                        shift_q <= slot_word_d;
                        cnt_q   <= cnt_d;
                    end
                end

                default: begin
                    locked_q <= 1'b0;
                    cnt_q    <= '0;
                    shift_q  <= '0;
                    state_q  <= ACQUIRE;
                end
            endcase
        end
    end

    assign left_sample  = left_sample_q;
    assign right_sample = right_sample_q;
    assign sample_valid = sample_valid_q;
    assign short_word   = short_word_q;
    assign sync_lost    = sync_lost_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Testbench for i2s_receiver. Stimulus is a sequence of I2S slots (channel,
// length, bit pattern). Expected frames and sync-loss events are derived per
// slot from the framing rules and queued; a separate monitor pops them when
// the DUT pulses sample_valid / sync_lost.
module tb_i2s_receiver;

    localparam int DW   = 16;
    localparam int MAXB = 32;

    logic          serial_clk   = 1'b0;
    logic          reset        = 1'b0;
    logic          word_select  = 1'b1;
    logic          sound_bit_in = 1'b0;
    logic [DW-1:0] left_sample;
    logic [DW-1:0] right_sample;
    logic          sample_valid;
    logic          short_word;
    logic          sync_lost;
    logic          locked;

    i2s_receiver #(.DATA_WIDTH(DW), .MAX_SLOT_BITS(MAXB)) dut (
        .serial_clk   (serial_clk),
        .reset        (reset),
        .word_select  (word_select),
        .sound_bit_in (sound_bit_in),
        .left_sample  (left_sample),
        .right_sample (right_sample),
        .sample_valid (sample_valid),
        .short_word   (short_word),
        .sync_lost    (sync_lost),
        .locked       (locked)
    );

    always #5 serial_clk = ~serial_clk;

    typedef struct packed {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        logic          s;
    } frame_t;

    frame_t exp_q[$];
    int     sync_exp = 0;
    int     checks   = 0;
    int     errors   = 0;

    // Reference model state
    bit            m_lk      = 1'b0;
    bit            m_prev_ws = 1'b0;
    logic [DW-1:0] m_left    = '0;
    logic [DW-1:0] m_right   = '0;
    bit            m_lshort  = 1'b0;
    bit            m_rshort  = 1'b0;
    logic          pending_bit = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Word kept from an n-bit slot whose bits (MSB first) form val.
    function automatic logic [DW-1:0] word_of(input longint unsigned val, input int n);
        longint unsigned w;
        if (n >= DW) w = val >> (n - DW);
        else         w = val << (DW - n);
        return w[DW-1:0];
    endfunction

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_left",   64'(left_sample),  64'h0);
        check("rst_right",  64'(right_sample), 64'h0);
        check("rst_valid",  64'(sample_valid), 64'h0);
        check("rst_short",  64'(short_word),   64'h0);
        check("rst_sync",   64'(sync_lost),    64'h0);
        check("rst_locked", 64'(locked),       64'h0);
        exp_q.delete();
        sync_exp  = 0;
        m_lk      = 1'b0;
        m_prev_ws = 1'b0;
        @(negedge serial_clk);
        reset = 1'b0;
    endtask

    // Drive one slot of n bits on channel c. abort_at >= 0 resets mid-slot.
    task automatic drive_slot(input bit c, input int n, input longint unsigned val, input int abort_at);
        bit captured;
        captured = 1'b0;
        if (c != m_prev_ws) begin
            if (m_lk && c == 1'b0) begin
                exp_q.push_back('{l: m_left, r: m_right, s: m_lshort | m_rshort});
                captured = 1'b1;
            end else if (m_lk) begin
                captured = 1'b1;
            end else if (c == 1'b0) begin
                m_lk     = 1'b1;
                captured = 1'b1;
            end
        end
        m_prev_ws = c;
        if (captured) begin
            if (n > MAXB) begin
                sync_exp++;
                m_lk = 1'b0;
            end else if (c == 1'b0) begin
                m_left   = word_of(val, n);
                m_lshort = (n < DW);
            end else begin
                m_right  = word_of(val, n);
                m_rshort = (n < DW);
            end
        end
        for (int j = 0; j < n; j++) begin
            @(negedge serial_clk);
            word_select  = c;
            sound_bit_in = pending_bit;
            pending_bit  = val[n-1-j];
            if (j == abort_at) begin
                do_reset();
                return;
            end
        end
    endtask

    task automatic frame(input int nl, input longint unsigned vl, input int nr, input longint unsigned vr);
        drive_slot(1'b0, nl, vl, -1);
        drive_slot(1'b1, nr, vr, -1);
    endtask

    function automatic longint unsigned rnd_bits(input int n);
        longint unsigned v;
        v = {$urandom, $urandom};
        return v & ((64'd1 << n) - 64'd1);
    endfunction

    function automatic int rnd_len();
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(MAXB + 1, MAXB + 4));
        return int'($urandom_range(1, MAXB));
    endfunction

    // Monitor
    initial begin
        logic [DW-1:0] last_l;
        logic [DW-1:0] last_r;
        frame_t        f;
        last_l = '0;
        last_r = '0;
        forever begin
            @(posedge serial_clk);
            #1;
            if (reset) begin
                check("rst_hold_valid", 64'(sample_valid), 64'h0);
                check("rst_hold_left",  64'(left_sample),  64'h0);
                last_l = '0;
                last_r = '0;
            end else begin
                if (sample_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame actual=%h/%h required=none @%0t",
                                 left_sample, right_sample, $time);
                    end else begin
                        f = exp_q.pop_front();
                        check("left",   64'(left_sample),  64'(f.l));
                        check("right",  64'(right_sample), 64'(f.r));
                        check("short",  64'(short_word),   64'(f.s));
                        check("locked_at_valid", 64'(locked), 64'h1);
                        $display("frame L=%h R=%h short=%0b expL=%h expR=%h expShort=%0b",
                                 left_sample, right_sample, short_word, f.l, f.r, f.s);
                    end
                    last_l = left_sample;
                    last_r = right_sample;
                end else begin
                    check("hold_left",  64'(left_sample),  64'(last_l));
                    check("hold_right", 64'(right_sample), 64'(last_r));
                end
                if (sync_lost) begin
                    checks++;
                    if (sync_exp == 0) begin
                        errors++;
                        $display("FAIL unexpected_sync_lost actual=1 required=0 @%0t", $time);
                    end else begin
                        sync_exp--;
                    end
                    check("locked_at_sync_lost", 64'(locked), 64'h0);
                    $display("sync_lost locked=%0b", locked);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        // Reset released while word_select=1 in the middle of a right slot.
        #1 reset = 1'b1;
        #1;
        check("init_left",   64'(left_sample),  64'h0);
        check("init_right",  64'(right_sample), 64'h0);
        check("init_valid",  64'(sample_valid), 64'h0);
        check("init_locked", 64'(locked),       64'h0);
        repeat (3) @(negedge serial_clk);
        reset = 1'b0;
        drive_slot(1'b1, 9, rnd_bits(9), -1);

        // Transmitter pattern: 17-bit slots, 0x7FFF then a pad bit, and 0.
        repeat (3) frame(17, 64'h7FFF << 1, 17, 64'h0);
        // 8-bit slots
        repeat (2) frame(8, 64'hA5, 8, 64'h3C);
        // 24-bit slots, extra bits dropped
        frame(24, 64'h123456, 24, rnd_bits(24));
        frame(16, 64'hBEEF, 16, 64'h1234);
        // Left overrun: 40 clocks without a transition
        frame(40, rnd_bits(40), 16, rnd_bits(16));
        repeat (2) frame(16, rnd_bits(16), 16, rnd_bits(16));
        // Right overrun
        frame(16, rnd_bits(16), 36, rnd_bits(36));
        frame(32, rnd_bits(32), 32, rnd_bits(32));   // exactly at the limit
        frame(1, 64'h1, 1, 64'h1);                    // shortest legal slots
        frame(33, rnd_bits(33), 16, rnd_bits(16));    // one bit over the limit
        frame(16, rnd_bits(16), 16, rnd_bits(16));
        // Reset between left MSB and LSB
        drive_slot(1'b0, 16, rnd_bits(16), 7);
        drive_slot(1'b1, 16, rnd_bits(16), -1);
        repeat (2) frame(16, rnd_bits(16), 16, rnd_bits(16));

        // Randomized frames
        for (int k = 0; k < 40; k++) begin
            int nl;
            int nr;
            nl = rnd_len();
            nr = rnd_len();
            frame(nl, rnd_bits(nl), nr, rnd_bits(nr));
        end

        // Close the final frame and let the monitor drain.
        drive_slot(1'b0, 4, rnd_bits(4), -1);
        repeat (3) @(negedge serial_clk);
        check("frames_pending",    64'(exp_q.size()), 64'h0);
        check("sync_lost_pending", 64'(sync_exp),     64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
